// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-register chain: bundle widths,
// handshake classification and the occupancy-width helper.
package pipe_pkg;

  localparam int MEM_WB_BUNDLE_W = 32;
  localparam int EX_MEM_BUNDLE_W = 64;
  localparam int MAX_STAGES      = 8;

  // Encoded as {input transfer, output transfer}
  typedef enum logic [1:0] {
    XFER_NONE = 2'b00,
    XFER_OUT  = 2'b01,
    XFER_IN   = 2'b10,
    XFER_BOTH = 2'b11
  } xfer_e;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Counter must hold 0..STAGES+1 (stages plus the optional skid entry)
  function automatic int occ_width(input int stages);
    return clog2(stages + 2);
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry input skid: parks a word while stage 0 is stalled so the upstream
// ready depends only on whether the skid entry is occupied.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = MEM_WB_BUNDLE_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_stage_ready,
  output logic              o_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_held
);

  logic              r_sv;
  logic [DATA_W-1:0] r_sd;
  logic              w_capture;
  logic              w_drain;

  assign w_capture = i_valid & ~r_sv & ~i_stage_ready & ~i_flush;
  assign w_drain   = r_sv & i_stage_ready;

  // A word accepted during a flush is dropped rather than parked
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sv <= 1'b0;
      r_sd <= '0;
    end else if (i_flush) begin
      r_sv <= 1'b0;
    end else if (w_capture) begin
      r_sv <= 1'b1;
      r_sd <= i_data;
    end else if (w_drain) begin
      r_sv <= 1'b0;
    end
  end

  assign o_ready = ~r_sv;
  assign o_valid = r_sv | i_valid;
  assign o_data  = r_sv ? r_sd : i_data;
  assign o_held  = r_sv;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic chain of STAGES valid/ready register stages with synchronous flush,
// optional input skid entry and a count of the entries currently held.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W = MEM_WB_BUNDLE_W,
  parameter int STAGES = 1,
  parameter int SKID   = 0
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Flush,
  input  logic                         In_Valid,
  output logic                         In_Ready,
  input  logic [DATA_W-1:0]            In_Data,
  output logic                         Out_Valid,
  input  logic                         Out_Ready,
  output logic [DATA_W-1:0]            Out_Data,
  output logic [occ_width(STAGES)-1:0] Occupancy
);

  localparam int OCC_W = occ_width(STAGES);

  logic [STAGES-1:0] w_v;
  logic [DATA_W-1:0] w_d [STAGES];
  logic [STAGES:0]   w_rdy;
  logic              w_src_v;
  logic [DATA_W-1:0] w_src_d;
  logic              w_skid_v;
  logic              w_in_xfer;
  logic              w_out_xfer;
  xfer_e             w_xfer;
  logic [OCC_W-1:0]  r_occ;
  logic [OCC_W-1:0]  w_held;

  // A stage can advance if it is empty or the stage after it advances
  always_comb begin
    w_rdy[STAGES] = Out_Ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_rdy[k] = w_rdy[k+1] | ~w_v[k];
    end
  end

  if (SKID != 0) begin : g_skid
    pipe_skid_buf #(
      .DATA_W(DATA_W)
    ) u_skid (
      .i_clk        (Clk),
      .i_rst_n      (Reset),
      .i_flush      (Flush),
      .i_valid      (In_Valid),
      .i_data       (In_Data),
      .i_stage_ready(w_rdy[0]),
      .o_ready      (In_Ready),
      .o_valid      (w_src_v),
      .o_data       (w_src_d),
      .o_held       (w_skid_v)
    );
  end else begin : g_direct
    assign In_Ready = w_rdy[0] & ~Flush;
    assign w_src_v  = In_Valid;
    assign w_src_d  = In_Data;
    assign w_skid_v = 1'b0;
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic              w_prev_v;
    logic [DATA_W-1:0] w_prev_d;
    logic              r_v;
    logic [DATA_W-1:0] r_d;

    if (gi == 0) begin : g_head
      assign w_prev_v = w_src_v;
      assign w_prev_d = w_src_d;
    end else begin : g_link
      assign w_prev_v = w_v[gi-1];
      assign w_prev_d = w_d[gi-1];
    end

    // Data only moves with a valid source, so a bubble leaves the old word
    always_ff @(posedge Clk) begin
      if (!Reset) begin
        r_v <= 1'b0;
        r_d <= '0;
      end else if (Flush) begin
        r_v <= 1'b0;
      end else if (w_rdy[gi]) begin
        r_v <= w_prev_v;
        if (w_prev_v) begin
          r_d <= w_prev_d;
        end
      end
    end

    assign w_v[gi] = r_v;
    assign w_d[gi] = r_d;
  end

  assign w_in_xfer  = In_Valid & In_Ready;
  assign w_out_xfer = w_v[STAGES-1] & Out_Ready;
  assign w_xfer     = xfer_e'({w_in_xfer, w_out_xfer});

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_occ <= '0;
    end else if (Flush) begin
      r_occ <= '0;
    end else begin
      unique case (w_xfer)
        XFER_IN:  r_occ <= r_occ + OCC_W'(1);
        XFER_OUT: r_occ <= r_occ - OCC_W'(1);
        default:  r_occ <= r_occ;
      endcase
    end
  end

  always_comb begin
    w_held = OCC_W'(w_skid_v);
    for (int k = 0; k < STAGES; k++) begin
      w_held = w_held + OCC_W'(w_v[k]);
    end
  end

  a_occ_matches_held: assert property (@(posedge Clk) disable iff (!Reset) r_occ == w_held);

  assign Out_Valid = w_v[STAGES-1];
  assign Out_Data  = w_d[STAGES-1];
  assign Occupancy = r_occ;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed and throttled-random checks of pipe_stage_elastic across several
// STAGES/SKID configurations sharing one clock.
module tb_pipe_stage_elastic;
  import pipe_pkg::*;

  localparam int N_DUT = 5;
  localparam int DW    = 8;
  localparam int ST [N_DUT] = '{3, 2, 2, 4, 4};
  localparam int SK [N_DUT] = '{0, 0, 1, 0, 1};

  logic          clk = 1'b0;
  logic          rst_n     [N_DUT];
  logic          flush     [N_DUT];
  logic          in_valid  [N_DUT];
  logic          in_ready  [N_DUT];
  logic [DW-1:0] in_data   [N_DUT];
  logic          out_valid [N_DUT];
  logic          out_ready [N_DUT];
  logic [DW-1:0] out_data  [N_DUT];
  int            occ       [N_DUT];

  int checks   = 0;
  int failures = 0;
  bit pending [N_DUT];
  int n_in    [N_DUT];
  int n_out   [N_DUT];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
    logic [occ_width(ST[gi])-1:0] occ_w;
    pipe_stage_elastic #(
      .DATA_W(DW),
      .STAGES(ST[gi]),
      .SKID  (SK[gi])
    ) u_dut (
      .Clk      (clk),
      .Reset    (rst_n[gi]),
      .Flush    (flush[gi]),
      .In_Valid (in_valid[gi]),
      .In_Ready (in_ready[gi]),
      .In_Data  (in_data[gi]),
      .Out_Valid(out_valid[gi]),
      .Out_Ready(out_ready[gi]),
      .Out_Data (out_data[gi]),
      .Occupancy(occ_w)
    );
    assign occ[gi] = int'(occ_w);
  end

  // Upstream rule for the randomly throttled instances
  bit          hold_q [N_DUT];
  bit [DW-1:0] data_q [N_DUT];
  always @(posedge clk) begin
    for (int u = 3; u < N_DUT; u++) begin
      if (hold_q[u]) assert (in_data[u] == data_q[u]) else $error("in_data moved while stalled on dut%0d", u);
      hold_q[u] <= in_valid[u] & ~in_ready[u];
      data_q[u] <= in_data[u];
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance.
  // ed/er of -1 skip the data/ready comparison.
  task automatic drive_check(input int u, input string tag, input bit iv, input int id,
                             input bit ordy, input bit fl, input int ev, input int ed,
                             input int eo, input int er);
    in_valid[u]  = iv;
    in_data[u]   = DW'(id);
    out_ready[u] = ordy;
    flush[u]     = fl;
    #1;
    check_eq({tag, ".out_valid"}, int'(out_valid[u]), ev);
    if (ed >= 0) check_eq({tag, ".out_data"}, int'(out_data[u]), ed);
    check_eq({tag, ".occ"}, occ[u], eo);
    if (er >= 0) check_eq({tag, ".in_ready"}, int'(in_ready[u]), er);
    if (out_valid[u] && out_ready[u])
      $display("dut%0d %s out 0x%02h", u, tag, out_data[u]);
    tick();
  endtask

  initial begin
    for (int u = 0; u < N_DUT; u++) begin
      rst_n[u] = 1'b0; flush[u] = 1'b0; in_valid[u] = 1'b0;
      in_data[u] = '0; out_ready[u] = 1'b0;
      pending[u] = 1'b0; n_in[u] = 0; n_out[u] = 0;
    end
    repeat (3) tick();
    for (int u = 0; u < N_DUT; u++) rst_n[u] = 1'b1;
    #1;
    for (int u = 0; u < N_DUT; u++) begin
      check_eq($sformatf("rst.dut%0d.out_valid", u), int'(out_valid[u]), 0);
      check_eq($sformatf("rst.dut%0d.out_data", u), int'(out_data[u]), 0);
      check_eq($sformatf("rst.dut%0d.occ", u), occ[u], 0);
      check_eq($sformatf("rst.dut%0d.in_ready", u), int'(in_ready[u]), 1);
    end
    tick();

    // STAGES=3 streaming: input of cycle t shows at the output in cycle t+3
    for (int t = 0; t < 10; t++) begin
      int ev;
      int acc;
      int del;
      ev  = (t >= 3 && t <= 7) ? 1 : 0;
      acc = (t < 5) ? t : 5;
      del = (t < 3) ? 0 : ((t - 3 > 5) ? 5 : t - 3);
      drive_check(0, $sformatf("seq.t%0d", t), t < 5, 'hA0 + t, 1'b1, 1'b0,
                  ev, (ev != 0) ? 'hA0 + t - 3 : -1, acc - del, 1);
    end

    // STAGES=2, SKID=0 stall and release
    drive_check(1, "stl.c0", 1'b1, 'h11, 1'b0, 1'b0, 0, -1,   0, 1);
    drive_check(1, "stl.c1", 1'b1, 'h22, 1'b0, 1'b0, 0, -1,   1, 1);
    drive_check(1, "stl.c2", 1'b0, 'h00, 1'b0, 1'b0, 1, 'h11, 2, 0);
    drive_check(1, "stl.c3", 1'b0, 'h00, 1'b0, 1'b0, 1, 'h11, 2, 0);
    drive_check(1, "stl.c4", 1'b0, 'h00, 1'b0, 1'b0, 1, 'h11, 2, 0);
    drive_check(1, "stl.c5", 1'b0, 'h00, 1'b0, 1'b0, 1, 'h11, 2, 0);
    drive_check(1, "stl.c6", 1'b0, 'h00, 1'b1, 1'b0, 1, 'h11, 2, 1);
    drive_check(1, "stl.c7", 1'b0, 'h00, 1'b1, 1'b0, 1, 'h22, 1, 1);
    drive_check(1, "stl.c8", 1'b0, 'h00, 1'b1, 1'b0, 0, -1,   0, 1);

    // STAGES=2, SKID=1: third word parks in the skid entry
    drive_check(2, "skd.c0", 1'b1, 'h11, 1'b0, 1'b0, 0, -1,   0, 1);
    drive_check(2, "skd.c1", 1'b1, 'h22, 1'b0, 1'b0, 0, -1,   1, 1);
    drive_check(2, "skd.c2", 1'b1, 'h33, 1'b0, 1'b0, 1, 'h11, 2, 1);
    drive_check(2, "skd.c3", 1'b0, 'h00, 1'b0, 1'b0, 1, 'h11, 3, 0);
    drive_check(2, "skd.c4", 1'b0, 'h00, 1'b0, 1'b0, 1, 'h11, 3, 0);
    drive_check(2, "skd.c5", 1'b0, 'h00, 1'b0, 1'b0, 1, 'h11, 3, 0);
    drive_check(2, "skd.c6", 1'b0, 'h00, 1'b1, 1'b0, 1, 'h11, 3, 0);
    drive_check(2, "skd.c7", 1'b0, 'h00, 1'b1, 1'b0, 1, 'h22, 2, 1);
    drive_check(2, "skd.c8", 1'b0, 'h00, 1'b1, 1'b0, 1, 'h33, 1, 1);
    drive_check(2, "skd.c9", 1'b0, 'h00, 1'b1, 1'b0, 0, -1,   0, 1);

    // STAGES=3 flush of a full chain; 0x51 still leaves in the flush cycle
    drive_check(0, "fls.c0", 1'b1, 'h51, 1'b0, 1'b0, 0, -1,   0, 1);
    drive_check(0, "fls.c1", 1'b1, 'h52, 1'b0, 1'b0, 0, -1,   1, 1);
    drive_check(0, "fls.c2", 1'b1, 'h53, 1'b0, 1'b0, 0, -1,   2, 1);
    drive_check(0, "fls.c3", 1'b1, 'h55, 1'b1, 1'b1, 1, 'h51, 3, 0);
    drive_check(0, "fls.c4", 1'b0, 'h55, 1'b1, 1'b0, 0, 'h51, 0, 1);
    for (int t = 5; t < 9; t++)
      drive_check(0, $sformatf("fls.c%0d", t), 1'b0, 'h00, 1'b1, 1'b0, 0, -1, 0, 1);

    // Reset mid-stream beats a coincident flush and input
    drive_check(0, "rsm.c0", 1'b1, 'h61, 1'b0, 1'b0, 0, -1, 0, 1);
    drive_check(0, "rsm.c1", 1'b1, 'h62, 1'b0, 1'b0, 0, -1, 1, 1);
    rst_n[0] = 1'b0;
    drive_check(0, "rsm.c2", 1'b1, 'h63, 1'b0, 1'b1, 0, -1, 2, 0);
    rst_n[0] = 1'b1;
    drive_check(0, "rsm.c3", 1'b0, 'h00, 1'b0, 1'b0, 0, 0,  0, 1);
    drive_check(0, "rsm.c4", 1'b1, 'h07, 1'b1, 1'b0, 0, 0,  0, 1);
    drive_check(0, "rsm.c5", 1'b0, 'h00, 1'b1, 1'b0, 0, -1, 1, 1);
    drive_check(0, "rsm.c6", 1'b0, 'h00, 1'b1, 1'b0, 0, -1, 1, 1);
    drive_check(0, "rsm.c7", 1'b0, 'h00, 1'b1, 1'b0, 1, 'h07, 1, 1);
    drive_check(0, "rsm.c8", 1'b0, 'h00, 1'b1, 1'b0, 0, -1, 0, 1);

    // STAGES=4 with and without skid: throttled traffic, then drain
    for (int c = 0; c < 10020; c++) begin
      for (int u = 3; u < N_DUT; u++) begin
        if (!pending[u]) in_valid[u] = (c < 10000) && ($urandom_range(9) < 7);
        in_data[u]   = DW'(n_in[u]);
        out_ready[u] = (c >= 10000) || ($urandom_range(9) < 6);
      end
      #1;
      for (int u = 3; u < N_DUT; u++) begin
        check_eq($sformatf("rnd%0d.c%0d.occ", u, c), occ[u], n_in[u] - n_out[u]);
        if (n_in[u] == n_out[u])
          check_eq($sformatf("rnd%0d.c%0d.out_valid", u, c), int'(out_valid[u]), 0);
        if (out_valid[u] && out_ready[u]) begin
          check_eq($sformatf("rnd%0d.c%0d.out_data", u, c), int'(out_data[u]), n_out[u] & 255);
          n_out[u]++;
        end
        if (in_valid[u] && in_ready[u]) n_in[u]++;
        pending[u] = in_valid[u] && !in_ready[u];
      end
      tick();
    end
    for (int u = 3; u < N_DUT; u++) begin
      check_eq($sformatf("rnd%0d.drained.occ", u), occ[u], 0);
      $display("dut%0d random phase: %0d in, %0d out", u, n_in[u], n_out[u]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed MEM/WB-style pipeline registers: an elastic chain of STAGES data registers with a valid/ready handshake per stage.
- Also provides a synchronous flush, an optional input skid buffer and an occupancy counter.
- Sits between any two processor pipeline stages, e.g. MEM->WB or a multi-cycle ALU path.
- The packed control/data bundle is carried opaquely as In_Data; stalls come from downstream backpressure, not free-running capture.

Parameters:
- DATA_W, 32: width of the carried bundle in bits; legal range 1..256.
- STAGES, 1: number of register stages; legal range 1..8.
- SKID, 0: 0 = In_Ready is combinational from downstream; 1 = a 1-entry input skid buffer makes In_Ready a registered signal.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  one clock; synchronous, active-low reset (Reset=0 at a rising Clk edge resets the block).
- Flush  in  1  synchronous pipeline flush, active-high.
- In_Valid  in  1  upstream holds a valid bundle.
- In_Ready  out  1  block accepts In_Data this cycle.
- In_Data  in  DATA_W  upstream bundle.
- Out_Valid  out  1  last stage holds a valid bundle.
- Out_Ready  in  1  downstream accepts this cycle.
- Out_Data  out  DATA_W  last-stage bundle.
- Occupancy  out  $clog2(STAGES+2)  number of valid entries held, including the skid entry.

Behaviour:
- State:
  - v[k], d[k] for k=0..STAGES-1.
  - sv, sd when SKID=1.
  - occupancy counter occ.
- Reset (Reset=0 at a Clk edge):
  - all v[k], sv and occ cleared to 0; all d[k] and sd cleared to 0.
  - So Out_Valid=0, Out_Data=0, Occupancy=0.
  - In_Ready=1 from the first cycle after reset (for SKID=1, sv=0).
  - Reset has priority over Flush and over all handshakes.
- Ready chain (combinational):
  - r[STAGES]=Out_Ready.
  - r[k]=r[k+1] | ~v[k].
  - Out_Valid=v[STAGES-1], Out_Data=d[STAGES-1].
- Stage advance, when r[k]=1 at a Clk edge:
  - v[k]<=source valid.
  - d[k]<=source data only if source valid; otherwise d[k] holds.
  - Source of stage k>0 is stage k-1. Source of stage 0 is the input path.
  - When r[k]=0, v[k] and d[k] hold.
- Input path, SKID=0:
  - In_Ready = r[0] & ~Flush.
  - Stage 0 source = (In_Valid, In_Data).
- Input path, SKID=1:
  - In_Ready = ~sv, registered and independent of Out_Ready and Flush.
  - Stage 0 source = sv ? (1, sd) : (In_Valid, In_Data).
  - Capture: if In_Valid & In_Ready & ~r[0] & ~Flush, then sv<=1 and sd<=In_Data.
  - Drain: if sv & r[0], then sv<=0.
  - Capture and drain cannot coincide, because capture requires sv=0.
- Handshakes:
  - Input transfer = In_Valid & In_Ready.
  - Output transfer = Out_Valid & Out_Ready.
  - In_Data is sampled only on an input transfer.
  - Upstream must hold In_Data stable while In_Valid=1 & In_Ready=0; the bench asserts this.
- Latency and throughput:
  - With no backpressure, an input accepted at edge N appears on Out_Data/Out_Valid after edge N+STAGES-1, so the output handshake occurs at edge N+STAGES.
  - STAGES=1 gives exactly the legacy register timing.
  - The skid entry adds no latency when empty.
  - Sustained throughput is one transfer per cycle under continuous Out_Ready=1.
- Flush (Flush=1 at an edge, Reset=1):
  - all v[k] and sv cleared; occ<=0.
  - d[k] and sd hold.
  - No input is accepted that cycle: SKID=0 forces In_Ready=0; with SKID=1 a coincident input transfer is discarded.
  - An output transfer that completes in the flush cycle counts as delivered; downstream sees it.
- Occupancy:
  - occ<=occ + input transfer - output transfer; flush overrides to 0.
  - Must always equal popcount(v)+sv; checked by assertion.
  - Maximum value is STAGES+SKID, so the counter never wraps.
- Boundary cases:
  - Full chain with Out_Ready=0: all stages hold; In_Ready=0 (SKID=0) or In_Ready=1 until the skid fills (SKID=1).
  - Full chain with Out_Ready=1: the whole chain shifts and accepts one new entry in the same cycle.
  - Bubbles collapse: an empty stage is refilled even while a later stage is stalled.

Decomposition:
- Shared package pipe_pkg holds:
  - function clog2 (localparam helper);
  - localparam OCC_W = clog2(STAGES+2);
  - default DATA_W constant for the bundle widths used by the processor (e.g. MEM_WB_BUNDLE_W).
- One natural sub-module: pipe_skid_buf, the one-entry skid (sv/sd, In_Ready generation), instantiated via generate only when SKID=1.
- The stage chain is a generate loop in the top.

Test Plan:
- STAGES=3, SKID=0, Out_Ready=1, inputs 0xA0..0xA4 on consecutive cycles -> identical sequence on Out_Data; first Out_Valid 2 cycles after first acceptance; Occupancy steady at 3.
- STAGES=2, SKID=0, fill with 0x11,0x22, then Out_Ready=0 for 4 cycles -> In_Ready=0, Out_Data=0x11 held, Occupancy=2; release -> 0x11 then 0x22 out, no loss or duplicates.
- STAGES=2, SKID=1, same stall -> third word 0x33 accepted into the skid, In_Ready falls to 0 next cycle, Occupancy=3; release -> order 0x11,0x22,0x33.
- Full pipe plus Flush=1 with In_Valid=1 (0x55) -> next cycle Out_Valid=0, Occupancy=0; 0x55 never appears at the output.
- Reset=0 asserted mid-stream with Flush=1 and In_Valid=1 -> next cycle all outputs 0, In_Ready=1; Reset=1 then a single input 0x7 emerges after STAGES cycles.
- Random valid/ready throttling, 10k cycles, STAGES=4, SKID in {0,1} -> scoreboard order matches, Occupancy == popcount(v)+sv every cycle, In_Data stability assertion never fires.
